// File: rtl/joy_scan_pkg.sv
// Shared constants, FSM encoding and the slot-to-bit map for the joystick
// shift-register scanner.
package joy_scan_pkg;

    localparam int NUM_SLOTS = 26;
    localparam logic [4:0] FIRST_SAMPLE_SLOT = 5'd2;
    localparam logic [4:0] LAST_SLOT = 5'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        EVAL  = 2'd3
    } state_t;

    // player: 0 = joystick 1, 1 = joystick 2
    typedef struct packed {
        logic       player;
        logic [3:0] bit_idx;
    } slot_map_t;

    // Order in which the external register presents the button bits.
    function automatic slot_map_t slot_map(input logic [4:0] slot);
        slot_map_t m;
        m = '{player: 1'b0, bit_idx: 4'd0};
        case (slot)
            5'd2:  m = '{player: 1'b0, bit_idx: 4'd8};
            5'd3:  m = '{player: 1'b0, bit_idx: 4'd6};
            5'd4:  m = '{player: 1'b0, bit_idx: 4'd5};
            5'd5:  m = '{player: 1'b0, bit_idx: 4'd4};
            5'd6:  m = '{player: 1'b0, bit_idx: 4'd3};
            5'd7:  m = '{player: 1'b0, bit_idx: 4'd2};
            5'd8:  m = '{player: 1'b0, bit_idx: 4'd1};
            5'd9:  m = '{player: 1'b0, bit_idx: 4'd0};
            5'd10: m = '{player: 1'b1, bit_idx: 4'd8};
            5'd11: m = '{player: 1'b1, bit_idx: 4'd6};
            5'd12: m = '{player: 1'b1, bit_idx: 4'd5};
            5'd13: m = '{player: 1'b1, bit_idx: 4'd4};
            5'd14: m = '{player: 1'b1, bit_idx: 4'd3};
            5'd15: m = '{player: 1'b1, bit_idx: 4'd2};
            5'd16: m = '{player: 1'b1, bit_idx: 4'd1};
            5'd17: m = '{player: 1'b1, bit_idx: 4'd0};
            5'd18: m = '{player: 1'b1, bit_idx: 4'd10};
            5'd19: m = '{player: 1'b1, bit_idx: 4'd11};
            5'd20: m = '{player: 1'b1, bit_idx: 4'd9};
            5'd21: m = '{player: 1'b1, bit_idx: 4'd7};
            5'd22: m = '{player: 1'b0, bit_idx: 4'd10};
            5'd23: m = '{player: 1'b0, bit_idx: 4'd11};
            5'd24: m = '{player: 1'b0, bit_idx: 4'd9};
            5'd25: m = '{player: 1'b0, bit_idx: 4'd7};
            default: m = '{player: 1'b0, bit_idx: 4'd0};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/joy_clk_div.sv
// Half-period divider for the joystick shift clock. Held at count 0 with the
// clock low whenever the scan is not running, so every slot starts clean.
module joy_clk_div #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic joy_clk,
    output logic slot_end
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;
    logic             tick;

    assign tick = run && (count == CNT_LAST);
    // A tick while high is the last cycle of the slot and the sample point.
    assign slot_end = tick && joy_clk;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            joy_clk <= 1'b0;
        end else if (tick) begin
            joy_clk <= ~joy_clk;
        end
    end

endmodule

// File: rtl/joy_serial_scanner.sv
// Scans the two-player joystick shift register, deserialises each 26-slot
// frame and commits the words only after they repeat for STABLE_FRAMES frames.
module joy_serial_scanner
    import joy_scan_pkg::*;
#(
    parameter int CLK_DIV       = 16,
    parameter int STABLE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_en,
    input  logic        joy_data,
    output logic        joy_clk,
    output logic        joy_load,
    output logic [11:0] joystick1,
    output logic [11:0] joystick2,
    output logic        frame_done,
    output logic        changed
);

    localparam logic [2:0] STABLE_MAX = 3'(STABLE_FRAMES);

    state_t      state;
    state_t      state_next;
    logic        run;
    logic        slot_end;
    logic [4:0]  slot;
    slot_map_t   map;
    logic        sample;
    logic        joy_data_p0;
    logic        joy_data_p1;
    logic [11:0] sh1;
    logic [11:0] sh2;
    logic [23:0] frame_word;
    logic [23:0] prev;
    logic [2:0]  stable_cnt;
    logic [2:0]  cnt_next;
    logic        commit;

    assign run = (state == LOAD) || (state == SHIFT);

    joy_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .joy_clk  (joy_clk),
        .slot_end (slot_end)
    );

    // joy_data is asynchronous to clk
    always_ff @(posedge clk) begin
        if (reset) begin
            joy_data_p0 <= 1'b1;
            joy_data_p1 <= 1'b1;
        end else begin
            joy_data_p0 <= joy_data;
            joy_data_p1 <= joy_data_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (scan_en) state_next = LOAD;
            LOAD:  if (slot_end) state_next = SHIFT;
            SHIFT: if (slot_end && (slot == LAST_SLOT)) state_next = EVAL;
            EVAL:  state_next = scan_en ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        joy_load   = (state != LOAD);
        frame_done = (state == EVAL);
    end

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            slot <= 5'd0;
        end else if (slot_end) begin
            slot <= slot + 5'd1;
        end
    end

    assign map    = slot_map(slot);
    assign sample = (state == SHIFT) && slot_end && (slot >= FIRST_SAMPLE_SLOT);

    always_ff @(posedge clk) begin
        if (reset) begin
            sh1 <= 12'hFFF;
            sh2 <= 12'hFFF;
        end else if (sample) begin
            if (map.player) begin
                sh2[map.bit_idx] <= joy_data_p1;
            end else begin
                sh1[map.bit_idx] <= joy_data_p1;
            end
        end
    end

    // Stability filter: the count saturates so a held input keeps committing.
    assign frame_word = {sh1, sh2};

    always_comb begin
        cnt_next = 3'd1;
        if (frame_word == prev) begin
            cnt_next = (stable_cnt >= STABLE_MAX) ? STABLE_MAX : stable_cnt + 3'd1;
        end
    end

    assign commit = (cnt_next >= STABLE_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= '1;
            stable_cnt <= 3'd0;
            joystick1  <= 12'hFFF;
            joystick2  <= 12'hFFF;
            changed    <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (state == EVAL) begin
                prev       <= frame_word;
                stable_cnt <= cnt_next;
                if (commit) begin
                    joystick1 <= sh1;
                    joystick2 <= sh2;
                    changed   <= (frame_word != {joystick1, joystick2});
                end
            end
        end
    end

endmodule

// File: doc/joy_serial_scanner.md
Name: joy_serial_scanner

Overview:
Synchronous controller for the external two-player joystick shift register (JOY_CLK / JOY_LOAD / JOY_DATA). It generates the load and shift-clock sequence from the system clock, deserialises a 26-slot frame into two active-low 12-bit joystick words, and filters the words over consecutive frames before committing them. It sits in the board top beside the arcade core. Its outputs feed I_JOYSTICK_A/B, I_PLAYER, I_COIN and the reset/reboot logic.

Parameters:
CLK_DIV, 16, clk cycles per JOY_CLK half-period; legal range 4..255.
STABLE_FRAMES, 2, consecutive identical frames required before commit; legal range 1..4.

Ports:
clk  in  1  system clock (pclk domain)
reset  in  1  synchronous, active-high
scan_en  in  1  1 = run continuous frames; 0 = stop after the current frame completes
joy_data  in  1  serial data from the shift register; asynchronous
joy_clk  out  1  shift clock to the register
joy_load  out  1  active-low parallel load
joystick1  out  12  committed player-1 word, active-low
joystick2  out  12  committed player-2 word, active-low
frame_done  out  1  one-cycle pulse at the end of every frame
changed  out  1  one-cycle pulse, coincident with a commit that altered joystick1 or joystick2

Behaviour:
- Clocking: the clock is clk. Reset is synchronous and active-high. Everything is in the single clk domain.
- joy_data passes through a 2-flop synchroniser, reset to 1.
- Divider:
  - The divider counts 0..CLK_DIV-1.
  - A half-period tick occurs when the count reaches CLK_DIV-1.
  - joy_clk toggles on each tick while the scan is active.
  - One slot = one JOY_CLK period = 2*CLK_DIV cycles (low phase first).
- Frame = slots 0..25, tracked by a 5-bit slot counter:
  - Slot 0: joy_load=0 for the whole slot.
  - Slot 1: dummy; no sample.
  - Slots 2..25: sample.
  - joy_load=1 in all slots other than slot 0.
- Sampling: take the synchronised joy_data on the last clk cycle of each high phase in slots 2..25.
- Slot-to-bit mapping (shared constant table):
  - Slot 2 -> j1[8]; slot 3 -> j1[6]; slots 4..9 -> j1[5..0].
  - Slot 10 -> j2[8]; slot 11 -> j2[6]; slots 12..17 -> j2[5..0].
  - Slot 18 -> j2[10]; 19 -> j2[11]; 20 -> j2[9]; 21 -> j2[7].
  - Slot 22 -> j1[10]; 23 -> j1[11]; 24 -> j1[9]; 25 -> j1[7].
- Samples go into shadow registers sh1/sh2.
- FSM states:
  - IDLE: joy_clk=0, joy_load=1, divider held at 0.
    - Go to LOAD when scan_en=1.
  - LOAD: slot 0.
    - Go to SHIFT at the end of slot 0.
  - SHIFT: slots 1..25.
    - Go to EVAL after the sample in slot 25, on the end-of-high tick.
  - EVAL: one cycle.
    - Pulse frame_done.
    - Run the stability filter.
    - Go to LOAD if scan_en=1, else IDLE.
- Stability filter, run in EVAL:
  - If {sh1,sh2} equals the previous frame's value prev, increment stable_cnt, saturating at STABLE_FRAMES.
  - Otherwise set stable_cnt=1.
  - Always copy {sh1,sh2} into prev.
  - When the new stable_cnt is >= STABLE_FRAMES, load joystick1=sh1 and joystick2=sh2.
  - changed=1 in that same cycle iff the loaded value differs from the old outputs.
  - With STABLE_FRAMES=1, every frame commits.
- Output timing: joystick1/2 update on the clk edge ending EVAL, i.e. one cycle after the final sample tick.
- scan_en deasserted mid-frame: the frame runs to EVAL (with commit), then the FSM goes to IDLE.
- Reset mid-frame: the partial frame is discarded. Next state is IDLE.
- Reset values: joystick1=joystick2=12'hFFF, prev=all ones, stable_cnt=0, sh1=sh2=12'hFFF, joy_clk=0, joy_load=1, frame_done=0, changed=0.

Decomposition:
- Package joy_scan_pkg holds:
  - NUM_SLOTS=26, FIRST_SAMPLE_SLOT=2.
  - FSM state enum {IDLE, LOAD, SHIFT, EVAL}.
  - The slot-to-(player,bit) mapping table as a constant function.
- One sub-module, joy_clk_div: the divider and tick generator, plus the joy_clk phase register.
- The FSM, deserialiser and filter stay in the top module.

Test Plan:
- Reset release, then a model shifting all ones:
  - With scan_en=0, joystick1/2 stay 12'hFFF and joy_load stays 1.
  - With scan_en=1 and CLK_DIV=4, the first frame_done comes 208 cycles after leaving IDLE, and changed stays 0.
- Model presents a j1 pattern 12'hFFE (fire pressed), STABLE_FRAMES=2:
  - After frame 1, joystick1 is still FFF.
  - After frame 2, joystick1=FFE, with changed=1 for exactly one cycle.
- Mapping check:
  - Drive slot 19 low only -> joystick2=12'h7FF, joystick1=FFF.
  - Drive slot 23 low only -> joystick1=12'h7FF.
- Glitch rejection, STABLE_FRAMES=2: drive one frame with j2 bit0 low between all-ones frames -> no commit and no changed pulse.
- Drop scan_en in slot 10 -> frame completes with frame_done, then IDLE: joy_clk=0, joy_load=1, with no further toggles for 1000 cycles.
- Assert reset in slot 15 with the pattern held -> outputs return to FFF on the next cycle, and the next frame starts with a full 2*CLK_DIV-cycle joy_load low.
